acc_alu_responder: RTL
======================

// Module: acc_alu_responder
// PURPOSE
//  Responder endpoint of the accelerator request/response protocol. It sits on one
//  slave port of the accelerator interconnect and executes offloaded integer
//  operations: single-cycle add/sub, and iterative multiply, multiply-high and
//  multiply-accumulate. The request id is returned unchanged so that the
//  interconnect can route each response back to its requester.
// PARAMETERS
//  DataWidth  32  operand and result width; must be >= 2
//  IdWidth    6   request/response id width; equals 5 + the requester index width
// PORTS
//  clk_i          in   1          clock; everything is on the rising edge
//  rst_i          in   1          synchronous reset, active-high
//  q_valid_i      in   1          request valid
//  q_ready_o      out  1          request ready
//  q_data_arga_i  in   DataWidth  operand a
//  q_data_argb_i  in   DataWidth  operand b
//  q_data_argc_i  in   DataWidth  operand c (used by MAC only)
//  q_data_op_i    in   32         operation word; only bits [2:0] are decoded
//  q_id_i         in   IdWidth    request id
//  p_valid_o      out  1          response valid
//  p_ready_i      in   1          response ready
//  p_data_o       out  DataWidth  result
//  p_error_o      out  1          1 = illegal opcode
//  p_id_o         out  IdWidth    id echoed from the request
// BEHAVIOUR
//  Reset: state=IDLE. p_valid_o, p_data_o, p_error_o, p_id_o and the counter are 0.
//   q_ready_o is 0 while rst_i is high, then 1 in IDLE.
//  Accept: a request is accepted in cycle k when q_valid_i & q_ready_o.
//   Operands, op and id are registered at that edge.
//  Ready rule: q_ready_o = (state==IDLE) | (state==RESP & p_ready_i).
//   q_ready_o is combinational from p_ready_i only.
//  Opcodes, selected by op[2:0]:
//   0 ADD   a+b
//   1 SUB   a-b
//   2 MUL   low half of a*b
//   3 MULH  high half of unsigned a*b
//   4 MAC   low half of (a*b)+c
//   5-7     illegal: p_error_o=1, p_data_o=0
//   All results wrap modulo 2^DataWidth; the product is 2*DataWidth wide.
//  FSM IDLE -> EXEC -> RESP:
//   - IDLE, on accept:
//       ADD/SUB/illegal: compute and go to RESP.
//       MUL/MULH/MAC: clear the 2*DataWidth accumulator, cnt=0, go to EXEC.
//   - EXEC: radix-2 shift-add with one bit of b per cycle, LSB first.
//       After cnt reaches DataWidth-1, go to RESP.
//       MAC adds c in the final EXEC cycle.
//   - RESP: p_valid_o=1.
//       On p_ready_i with no new accept, go to IDLE.
//       On p_ready_i with a simultaneous accept, handle it exactly as the IDLE
//       accept (back-to-back).
//  Latency, with the request accepted in cycle k:
//   - ADD/SUB/illegal: p_valid_o is high from cycle k+1.
//   - MUL/MULH/MAC: p_valid_o is high from cycle k+1+DataWidth.
//  One transaction is in flight at a time; there is no internal queue.
//  Stability: while p_valid_o & ~p_ready_i, all p_* outputs hold constant.
//   p_valid_o never drops without a handshake.
//  Request inputs are ignored unless accepted. Values present while q_ready_o=0
//   must not corrupt state.
//  Reset mid-operation, in EXEC or RESP: the transaction is dropped with no
//   response. Reset outputs appear from the next cycle.
// TESTING
//  - ADD a=5 b=7 id=0x21, p_ready=1 -> p_valid at k+1, data=12, error=0, id=0x21.
//  - SUB a=3 b=5 -> data=0xFFFFFFFE at k+1. Back-to-back ADD accepted in the same
//    cycle as the response handshake -> its response at the next cycle.
//  - MUL a=b=0xFFFFFFFF -> data=0x00000001 at k+33. MULH with the same operands
//    -> 0xFFFFFFFE at k+33. q_ready=0 throughout EXEC.
//  - MAC a=3 b=4 c=0xFFFFFFFF -> data=0x0000000B. MUL a=0x10000 b=0x10000 -> 0.
//  - Hold p_ready=0 for 10 cycles after a MUL result -> p_* stable and q_ready=0.
//    Release -> one handshake, then IDLE.
//  - op=7 id=0x3F -> error=1, data=0, id=0x3F at k+1. Assert rst_i at k+10 of a MUL
//    -> no response, all outputs 0, and the next ADD works normally.

Source files
------------

// File: rtl/acc_alu_responder_if.sv
// Request/response bundle between the accelerator interconnect
// and one responder; signal suffixes are as seen by the responder.
interface acc_alu_responder_if #(
    parameter int DataWidth = 32,
    parameter int IdWidth   = 6
);
    logic                 q_valid_i;
    logic                 q_ready_o;
    logic [DataWidth-1:0] q_data_arga_i;
    logic [DataWidth-1:0] q_data_argb_i;
    logic [DataWidth-1:0] q_data_argc_i;
    logic [31:0]          q_data_op_i;
    logic [IdWidth-1:0]   q_id_i;
    logic                 p_valid_o;
    logic                 p_ready_i;
    logic [DataWidth-1:0] p_data_o;
    logic                 p_error_o;
    logic [IdWidth-1:0]   p_id_o;

    modport master (
        output q_valid_i, q_data_arga_i, q_data_argb_i,
        output q_data_argc_i, q_data_op_i, q_id_i, p_ready_i,
        input  q_ready_o, p_valid_o, p_data_o, p_error_o, p_id_o
    );

    modport slave (
        input  q_valid_i, q_data_arga_i, q_data_argb_i,
        input  q_data_argc_i, q_data_op_i, q_id_i, p_ready_i,
        output q_ready_o, p_valid_o, p_data_o, p_error_o, p_id_o
    );
endinterface

// File: rtl/acc_alu_responder.sv
// Accelerator responder: single-cycle add/sub, iterative
// shift-add multiply / multiply-high / multiply-accumulate.
module acc_alu_responder #(
    parameter int DataWidth = 32,
    parameter int IdWidth   = 6
) (
    input logic                clk_i,
    input logic                rst_i,
    acc_alu_responder_if.slave bus
);
    localparam int CntWidth  = $clog2(DataWidth);
    localparam int ProdWidth = 2 * DataWidth;

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpMul  = 3'd2;
    localparam logic [2:0] OpMulh = 3'd3;
    localparam logic [2:0] OpMac  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q;
    logic [2:0]            op_q;
    logic [ProdWidth-1:0]  a_q;
    logic [ProdWidth-1:0]  acc_q;
    logic [ProdWidth-1:0]  acc_d;
    logic [DataWidth-1:0]  b_q;
    logic [DataWidth-1:0]  c_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  p_valid_q;
    logic                  p_error_q;
    logic [DataWidth-1:0]  p_data_q;
    logic [IdWidth-1:0]    p_id_q;

    logic                  q_ready;
    logic                  accept;
    logic                  last;
    logic [2:0]            req_op;
    logic                  req_mul;
    logic                  req_err;
    logic [DataWidth-1:0]  req_data;
    logic                  unused_op_hi;

    assign req_op       = bus.q_data_op_i[2:0];
    assign unused_op_hi = ^bus.q_data_op_i[31:3];

    assign q_ready = ~rst_i & ((state_q == IDLE) |
                     ((state_q == RESP) & bus.p_ready_i));
    assign accept  = bus.q_valid_i & q_ready;
    assign last    = (cnt_q == CntWidth'(DataWidth - 1));

    // Decode an incoming request into a direct result or a multiply start
    always_comb begin
        req_data = '0;
        req_err  = 1'b0;
        req_mul  = 1'b0;
        case (req_op)
            OpAdd:  req_data = bus.q_data_arga_i + bus.q_data_argb_i;
            OpSub:  req_data = bus.q_data_arga_i - bus.q_data_argb_i;
            OpMul, OpMulh, OpMac: req_mul = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // One shift-add step; the MAC addend joins on the final step
    always_comb begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        if (last && (op_q == OpMac)) begin
            acc_d = acc_d + {{DataWidth{1'b0}}, c_q};
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            p_valid_q <= 1'b0;
            p_error_q <= 1'b0;
            p_data_q  <= '0;
            p_id_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        p_id_q <= bus.q_id_i;
                        if (req_mul) begin
                            a_q       <= {{DataWidth{1'b0}}, bus.q_data_arga_i};
                            b_q       <= bus.q_data_argb_i;
                            c_q       <= bus.q_data_argc_i;
                            op_q      <= req_op;
                            acc_q     <= '0;
                            cnt_q     <= '0;
                            p_valid_q <= 1'b0;
                            state_q   <= EXEC;
                        end else begin
                            p_valid_q <= 1'b1;
                            p_data_q  <= req_data;
                            p_error_q <= req_err;
                            state_q   <= RESP;
                        end
                    end else if ((state_q == RESP) && bus.p_ready_i) begin
                        p_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                EXEC: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        p_valid_q <= 1'b1;
                        p_error_q <= 1'b0;
                        p_data_q  <= (op_q == OpMulh) ?
                                     acc_d[ProdWidth-1:DataWidth] :
                                     acc_d[DataWidth-1:0];
                        state_q   <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.q_ready_o = q_ready;
    assign bus.p_valid_o = p_valid_q;
    assign bus.p_data_o  = p_data_q;
    assign bus.p_error_o = p_error_q;
    assign bus.p_id_o    = p_id_q;
endmodule
